// File: rtl/branch_unit.sv
// rtl/branch_unit.sv - program counter with run-time target tables and optional return-address stack (BRANCH_UNIT_RAS_EN)
module branch_unit #(
   parameter int PC_W      = 16,
   parameter int SEL_W     = 5,
   parameter int RAS_DEPTH = 4
) (
   input  logic                         CLK,
   input  logic                         reset,
   input  logic                         stall,
   input  logic                         br_abs,
   input  logic                         br_rel_z,
   input  logic                         br_rel_nz,
   input  logic                         call,
   input  logic                         ret,
   input  logic                         halt,
   input  logic                         zero_flag,
   input  logic [SEL_W-1:0]             sel,
   input  logic                         tbl_we,
   input  logic                         tbl_rel,
   input  logic [SEL_W-1:0]             tbl_waddr,
   input  logic [PC_W-1:0]              tbl_wdata,
   output logic [PC_W-1:0]              pc,
   output logic                         done,
   output logic [$clog2(RAS_DEPTH):0]   ras_count,
   output logic                         ras_ovf,
   output logic                         ras_unf
);

   localparam int N_ENT = 2**SEL_W;

   logic [PC_W-1:0] abs_tbl [N_ENT];
   logic [PC_W-1:0] rel_tbl [N_ENT];

   logic [PC_W-1:0] pc_inc;
   logic [PC_W-1:0] abs_tgt;
   logic [PC_W-1:0] rel_tgt;
   logic [PC_W-1:0] pc_next;
   logic            done_next;
   logic            advance;
   logic            rel_taken;

   assign pc_inc    = pc + 1'b1;
   assign abs_tgt   = abs_tbl[sel];
   assign rel_tgt   = pc + rel_tbl[sel];
   assign rel_taken = (br_rel_z && zero_flag) || (br_rel_nz && !zero_flag);
   assign advance   = !stall && !done;

`ifdef BRANCH_UNIT_RAS_EN
   localparam int PTR_W = $clog2(RAS_DEPTH);
   localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(RAS_DEPTH);
   localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   logic [PC_W-1:0]  ras_mem [RAS_DEPTH];
   logic [PTR_W-1:0] sp;   // next write slot; top of stack is sp-1
   logic [PC_W-1:0]  ras_top;
   logic             do_push;
   logic             do_pop;
   logic             unf_set;

   assign ras_top = ras_mem[sp - PTR_ONE];
`endif

   // Next-PC selection in priority order: halt, ret, call, absolute, relative, sequential
   always_comb begin
      pc_next   = pc;
      done_next = done;
`ifdef BRANCH_UNIT_RAS_EN
      do_push   = 1'b0;
      do_pop    = 1'b0;
      unf_set   = 1'b0;
`endif
      if (halt) begin
         done_next = 1'b1;
      end else if (ret) begin
`ifdef BRANCH_UNIT_RAS_EN
         if (ras_count != '0) begin
            pc_next = ras_top;
            do_pop  = 1'b1;
         end else begin
            pc_next = pc_inc;
            unf_set = 1'b1;
         end
`else
         pc_next = pc_inc;
`endif
      end else if (call) begin
         pc_next = abs_tgt;
`ifdef BRANCH_UNIT_RAS_EN
         do_push = 1'b1;
`endif
      end else if (br_abs) begin
         pc_next = abs_tgt;
      end else if (rel_taken) begin
         pc_next = rel_tgt;
      end else begin
         pc_next = pc_inc;
      end
   end

   // Target tables: cleared on reset, writable regardless of stall or done
   always_ff @(posedge CLK) begin
      if (reset) begin
         for (int i = 0; i < N_ENT; i++) begin
            abs_tbl[i] <= '0;
            rel_tbl[i] <= '0;
         end
      end else if (tbl_we) begin
         if (tbl_rel) rel_tbl[tbl_waddr] <= tbl_wdata;
         else         abs_tbl[tbl_waddr] <= tbl_wdata;
      end
   end

   // PC and halt state move only when neither stalled nor already halted
   always_ff @(posedge CLK) begin
      if (reset) begin
         pc   <= '0;
         done <= 1'b0;
      end else if (advance) begin
         pc   <= pc_next;
         done <= done_next;
      end
   end

`ifdef BRANCH_UNIT_RAS_EN
   // Stack pointer, occupancy and sticky error flags
   always_ff @(posedge CLK) begin
      if (reset) begin
         sp        <= '0;
         ras_count <= '0;
         ras_ovf   <= 1'b0;
         ras_unf   <= 1'b0;
      end else if (advance) begin
         if (do_push) begin
            sp <= sp + PTR_ONE;
            if (ras_count == CNT_FULL) ras_ovf   <= 1'b1;
            else                       ras_count <= ras_count + CNT_ONE;
         end
         if (do_pop) begin
            sp        <= sp - PTR_ONE;
            ras_count <= ras_count - CNT_ONE;
         end
         if (unf_set) ras_unf <= 1'b1;
      end
   end

   // Stack storage; when full the slot at sp holds the oldest entry, so a push overwrites it
   always_ff @(posedge CLK) begin
      if (!reset && advance && do_push) ras_mem[sp] <= pc_inc;
   end
`else
   assign ras_count = '0;
   assign ras_ovf   = 1'b0;
   assign ras_unf   = 1'b0;
`endif

endmodule

// File: doc/branch_unit.md
# branch_unit

Parametrised successor to the processor's fetch/branch logic: owns the program counter and resolves absolute, zero/non-zero relative, call and return transfers. Branch targets come from two run-time-writable target tables instead of fixed constants, with a hardware return-address stack. Sits between the controller and `InstROM`. `pc` drives the instruction address, and `done` signals the testbench that the program has finished.

## Interface
Parameters:
- `PC_W`, 16: PC and target width.
- `SEL_W`, 5: table index width; each table has 2^SEL_W entries.
- `RAS_DEPTH`, 4: return-stack entries, ≥2, power of two.

Ports:
- `CLK` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `stall` in 1: hold PC and stack this cycle.
- `br_abs` in 1: jump to `abs_tbl[sel]`.
- `br_rel_z` in 1: `pc += rel_tbl[sel]` if `zero_flag`.
- `br_rel_nz` in 1: `pc += rel_tbl[sel]` if `!zero_flag`.
- `call` in 1: push `pc+1`, jump to `abs_tbl[sel]`.
- `ret` in 1: pop into PC.
- `halt` in 1: stop fetching.
- `zero_flag` in 1: registered ALU zero flag.
- `sel` in SEL_W: table index.
- `tbl_we` in 1: table write enable.
- `tbl_rel` in 1: 1 = write `rel_tbl`, 0 = write `abs_tbl`.
- `tbl_waddr` in SEL_W: write index.
- `tbl_wdata` in PC_W: write data.
- `pc` out PC_W: current PC.
- `done` out 1: halted.
- `ras_count` out $clog2(RAS_DEPTH)+1: stack occupancy.
- `ras_ovf` out 1: sticky push-when-full.
- `ras_unf` out 1: sticky pop-when-empty.

## Operation
- Reset values:
  - `pc`=0, `done`=0, `ras_count`=0, `ras_ovf`=0, `ras_unf`=0.
  - All table entries are 0.
  - A table write in a reset cycle is ignored.
- Next-PC priority, evaluated only when `!stall && !done`:
  - `halt`: `done`←1, PC holds.
  - `ret`: non-empty → PC←top, count−1. Empty → PC←`pc+1`, `ras_unf`←1.
  - `call`: push `pc+1`, then PC←`abs_tbl[sel]`.
  - `br_abs`: PC←`abs_tbl[sel]`.
  - `br_rel_z`/`br_rel_nz`: if taken, PC←`pc + rel_tbl[sel]`. The table value is two's complement, and the sum wraps modulo 2^PC_W.
  - Otherwise: PC←`pc+1`, wrapping from 2^PC_W−1 to 0.
- Stack is circular:
  - A push when full overwrites the oldest entry.
  - In that case `ras_count` stays at RAS_DEPTH and `ras_ovf`←1.
- `done` is terminal: PC, stack and flags are frozen until `reset`. Table writes are still accepted.
- `stall` freezes PC, stack, `done` and flags. Table writes are still accepted.
- Table read is combinational from `sel`; table write is registered.
  - Same-cycle write and read of the same index returns the old value.
  - The new value is visible the next cycle.
- Sticky flags clear only on `reset`.

## Timing
- One-cycle latency: controls sampled at edge N produce the new `pc` after edge N.
- All outputs are registered; no combinational input→output path.
- `done` rises on the edge that samples `halt`.
- Reset asserted mid-program takes effect at the next edge and overrides every other input.

## Configuration
- `BRANCH_UNIT_RAS_EN` defined:
  - Return stack present, as described above.
- `BRANCH_UNIT_RAS_EN` undefined:
  - No stack storage.
  - `call` behaves exactly as `br_abs`.
  - `ret` behaves as sequential `pc+1`.
  - `ras_count`, `ras_ovf`, `ras_unf` tied to 0.

## Test plan
- Write `abs_tbl[3]`=0x0040 and `rel_tbl[3]`=0xFFFE (−2).
  - At `pc`=0x0010 with `br_abs`, `sel`=3 → `pc`=0x0040 next cycle.
  - Then `br_rel_z`, `zero_flag`=1 → `pc`=0x003E.
  - Then `br_rel_z`, `zero_flag`=0 → `pc`=0x003F.
- Nested calls 5 deep at PCs 0x10, 0x20, 0x30, 0x40, 0x50 (RAS_DEPTH=4):
  - `ras_ovf`=1, `ras_count`=4.
  - Four `ret` return to 0x51, 0x41, 0x31, 0x21.
  - A fifth `ret` → `pc+1` and `ras_unf`=1.
- At `pc`=0xFFFF with no branch → `pc`=0x0000.
- `stall` held 3 cycles while `br_abs` is asserted → `pc` unchanged throughout.
  - A table write made during the stall is read back correctly afterwards.
- `halt` with `call` asserted in the same cycle:
  - `done`=1, `pc` unchanged, `ras_count` unchanged.
  - Subsequent branches are ignored.
  - `reset` → `pc`=0, `done`=0, tables read 0.
- Build without `BRANCH_UNIT_RAS_EN`:
  - `call` to 0x0040 → `pc`=0x0040.
  - `ret` → 0x0041.
  - `ras_*` outputs stay 0.
